// File: rtl/mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the main-memory arbiter: FSM state encoding,
// transaction owner encoding and the cache-line offset width.
// No ports (package).
// ----------------------------------------------------------------------------
package mem_arbiter_pkg;

   // 16-byte lines: the low 4 address bits select a byte within the line
   localparam int LINE_OFFSET_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEM  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the instruction-cache, data-cache and main-memory handshakes seen
// by the arbiter.
//   slave  : the arbiter's view (takes cache requests and memory responses,
//            produces acks, returned lines and the memory request).
//   master : the environment's view (caches and main memory).
// Signals:
//   i_req/i_addr, i_ack/i_rdata                 instruction-side line reads
//   d_req/d_we/d_addr/d_wdata, d_ack/d_rdata    data-side reads/writebacks
//   err                                         timeout flag, pulses with ack
//   mem_req/mem_we/mem_addr/mem_wdata           memory request
//   mem_ready/mem_rdata                         memory completion
// ----------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [LINE_W-1:0] i_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic              d_ack;
   logic [LINE_W-1:0] d_rdata;
   logic              err;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [LINE_W-1:0] mem_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, err, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, err, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter putting instruction-side line refills and data-side
// line refills/writebacks onto a single main-memory port, one full-line
// transaction at a time, with a watchdog that ends transactions the memory
// never completes.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (cache handshakes + memory port)
// Parameters:
//   ADDR_W  : byte address width
//   LINE_W  : cache line width in bits
//   TIMEOUT : max MEM cycles waiting for mem_ready (0 disables the watchdog)
// ----------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 128,
   parameter int TIMEOUT = 64
) (
   input  logic          clock,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << LINE_OFFSET_W) - 1);

   state_t            r_state, w_state;
   owner_t            r_owner, w_owner;
   owner_t            r_last,  w_last;
   logic [TMR_W-1:0]  r_timer, w_timer;
   logic              r_mem_req,   w_mem_req;
   logic              r_mem_we,    w_mem_we;
   logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr;
   logic [LINE_W-1:0] r_mem_wdata, w_mem_wdata;
   logic              r_i_ack,     w_i_ack;
   logic              r_d_ack,     w_d_ack;
   logic              r_err,       w_err;
   logic [LINE_W-1:0] r_i_rdata,   w_i_rdata;
   logic [LINE_W-1:0] r_d_rdata,   w_d_rdata;
   logic              w_grant_d;
   logic              w_timeout;

   // Watchdog fires on the TIMEOUT-th MEM cycle; a coincident mem_ready wins.
   assign w_timeout = (TIMEOUT != 0) && (r_timer == TMR_LAST);

   always_comb begin
      w_state     = r_state;
      w_owner     = r_owner;
      w_last      = r_last;
      w_timer     = r_timer;
      w_mem_req   = r_mem_req;
      w_mem_we    = r_mem_we;
      w_mem_addr  = r_mem_addr;
      w_mem_wdata = r_mem_wdata;
      // ack, err and returned lines are single-cycle pulses
      w_i_ack     = 1'b0;
      w_d_ack     = 1'b0;
      w_err       = 1'b0;
      w_i_rdata   = '0;
      w_d_rdata   = '0;
      // Data wins if alone, or on a conflict when instruction went last
      w_grant_d   = bus.d_req & (~bus.i_req | (r_last == OWN_I));

      case (r_state)
         ST_IDLE: begin
            if (bus.i_req | bus.d_req) begin
               w_state     = ST_MEM;
               w_owner     = w_grant_d ? OWN_D : OWN_I;
               w_last      = w_owner;
               w_timer     = '0;
               w_mem_req   = 1'b1;
               w_mem_we    = w_grant_d & bus.d_we;
               w_mem_addr  = (w_grant_d ? bus.d_addr : bus.i_addr) & ~OFF_MASK;
               w_mem_wdata = w_grant_d ? bus.d_wdata : '0;
            end
         end
         ST_MEM: begin
            if (bus.mem_ready | w_timeout) begin
               w_state     = ST_RESP;
               w_mem_req   = 1'b0;
               w_mem_we    = 1'b0;
               w_mem_addr  = '0;
               w_mem_wdata = '0;
               w_err       = ~bus.mem_ready;
               if (r_owner == OWN_D) begin
                  w_d_ack = 1'b1;
                  if (bus.mem_ready && !r_mem_we) w_d_rdata = bus.mem_rdata;
               end else begin
                  w_i_ack = 1'b1;
                  if (bus.mem_ready) w_i_rdata = bus.mem_rdata;
               end
            end else begin
               w_timer = r_timer + TMR_W'(1);
            end
         end
         ST_RESP: begin
            w_state = ST_IDLE;
            w_timer = '0;
         end
         default: w_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_owner     <= OWN_I;
         r_last      <= OWN_I;
         r_timer     <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_i_ack     <= 1'b0;
         r_d_ack     <= 1'b0;
         r_err       <= 1'b0;
         r_i_rdata   <= '0;
         r_d_rdata   <= '0;
      end else begin
         r_state     <= w_state;
         r_owner     <= w_owner;
         r_last      <= w_last;
         r_timer     <= w_timer;
         r_mem_req   <= w_mem_req;
         r_mem_we    <= w_mem_we;
         r_mem_addr  <= w_mem_addr;
         r_mem_wdata <= w_mem_wdata;
         r_i_ack     <= w_i_ack;
         r_d_ack     <= w_d_ack;
         r_err       <= w_err;
         r_i_rdata   <= w_i_rdata;
         r_d_rdata   <= w_d_rdata;
      end
   end

   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.i_ack     = r_i_ack;
   assign bus.d_ack     = r_d_ack;
   assign bus.err       = r_err;
   assign bus.i_rdata   = r_i_rdata;
   assign bus.d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a transaction-level reference model,
// a per-cycle compare process, a memory responder with configurable latency,
// directed scenarios with literal expectations and a randomized phase.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   n_ack = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus();

   mem_arbiter #(.ADDR_W(32), .LINE_W(128), .TIMEOUT(TMO)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- memory responder ----------------
   // Latency L>0: mem_ready in the L-th cycle mem_req is seen high; 0: never.
   int           cfg_lat = -1;
   bit           cfg_data_en = 1'b0;
   logic [127:0] cfg_data = '0;
   bit           spur_en = 1'b0;
   bit           poke = 1'b0;
   int           rsp_cnt = 0;
   int           rsp_lat = 1;

   always @(negedge clk) begin
      if (!rst_n) begin
         bus.mem_ready = 1'b0;
         bus.mem_rdata = '0;
         rsp_cnt = 0;
      end else if (bus.mem_req) begin
         bus.mem_ready = (rsp_lat > 0) && (rsp_cnt == rsp_lat - 1);
         bus.mem_rdata = cfg_data_en ? cfg_data : rand128();
         rsp_cnt++;
      end else begin
         int v;
         v = $urandom_range(1, 10);
         rsp_cnt = 0;
         rsp_lat = (cfg_lat >= 0) ? cfg_lat : ((v == 10) ? 0 : v);
         bus.mem_ready = poke || (spur_en && ($urandom_range(0, 7) == 0));
         bus.mem_rdata = rand128();
      end
   end

   // ---------------- reference model ----------------
   // Transaction view: idle -> one outstanding line transfer -> one
   // completion cycle. Expected outputs are what must be visible after the edge.
   bit           m_busy, m_resp, m_own_d, m_last_d, m_we;
   int           m_age;
   logic [31:0]  m_addr;
   logic [127:0] m_wdata;
   bit           e_mem_req, e_mem_we, e_i_ack, e_d_ack, e_err;
   logic [31:0]  e_mem_addr;
   logic [127:0] e_mem_wdata, e_i_rdata, e_d_rdata;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_resp = 0; m_last_d = 0; m_age = 0;
         e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
         e_i_ack = 0; e_d_ack = 0; e_err = 0; e_i_rdata = '0; e_d_rdata = '0;
      end else begin
         e_i_ack = 0; e_d_ack = 0; e_err = 0; e_i_rdata = '0; e_d_rdata = '0;
         if (m_resp) begin
            m_resp = 0;
         end else if (!m_busy) begin
            if (bus.i_req || bus.d_req) begin
               m_own_d  = bus.d_req && !(bus.i_req && m_last_d);
               m_last_d = m_own_d;
               m_addr   = (m_own_d ? bus.d_addr : bus.i_addr) & 32'hFFFF_FFF0;
               m_we     = m_own_d && bus.d_we;
               m_wdata  = m_own_d ? bus.d_wdata : '0;
               m_busy   = 1; m_age = 0;
               e_mem_req = 1; e_mem_we = m_we; e_mem_addr = m_addr; e_mem_wdata = m_wdata;
            end
         end else begin
            m_age++;
            if (bus.mem_ready || m_age == TMO) begin
               m_busy = 0; m_resp = 1; e_mem_req = 0;
               e_err = !bus.mem_ready;
               if (m_own_d) begin
                  e_d_ack = 1;
                  e_d_rdata = (bus.mem_ready && !m_we) ? bus.mem_rdata : '0;
               end else begin
                  e_i_ack = 1;
                  e_i_rdata = bus.mem_ready ? bus.mem_rdata : '0;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         check("mem_req", bus.mem_req, e_mem_req);
         if (e_mem_req) begin
            check("mem_we", bus.mem_we, e_mem_we);
            check("mem_addr", bus.mem_addr, e_mem_addr);
            check("mem_wdata", bus.mem_wdata, e_mem_wdata);
         end
         check("i_ack", bus.i_ack, e_i_ack);
         check("d_ack", bus.d_ack, e_d_ack);
         check("err", bus.err, e_err);
         check("ack_excl", bus.i_ack & bus.d_ack, 1'b0);
         if (e_i_ack) check("i_rdata", bus.i_rdata, e_i_rdata);
         if (e_d_ack) check("d_rdata", bus.d_rdata, e_d_rdata);
         if (bus.i_ack || bus.d_ack) n_ack++;
         if (bus.err) n_err++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ack(input bit side_d, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(side_d ? bus.d_ack : bus.i_ack) && cyc < 40);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.i_req = 0; bus.d_req = 0;
      idle(2);
      rst_n = 1'b1;
   endtask

   task automatic step_rand();
      if (bus.i_ack) bus.i_req = 0;
      else if (!bus.i_req) begin
         if ($urandom_range(0, 3) == 0) begin bus.i_req = 1; bus.i_addr = $urandom(); end
      end else if ($urandom_range(0, 7) == 0) bus.i_addr = $urandom();
      if (bus.d_ack) bus.d_req = 0;
      else if (!bus.d_req) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.d_req = 1; bus.d_addr = $urandom();
            bus.d_we = 1'($urandom_range(0, 1)); bus.d_wdata = rand128();
         end
      end else if ($urandom_range(0, 7) == 0) begin
         bus.d_addr = $urandom(); bus.d_wdata = rand128();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

   initial begin
      int cyc, cnt, ng, guard;
      bit prev_req, i_rearm, d_rearm;
      logic [31:0] order [4];
      logic [31:0] exp_order [4];

      bus.i_req = 0; bus.i_addr = '0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;

      // Reset state
      idle(3);
      check("rst_mem_req", bus.mem_req, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_i_ack", bus.i_ack, 1'b0);
      check("rst_d_ack", bus.d_ack, 1'b0);
      check("rst_err", bus.err, 1'b0);
      rst_n = 1'b1;

      // Instruction read, memory answers in the 3rd cycle
      cfg_lat = 3; cfg_data_en = 1; cfg_data = {32{4'hA}};
      idle(2);
      bus.i_req = 1; bus.i_addr = 32'h0000_1234;
      @(negedge clk);
      check("t1_mem_req", bus.mem_req, 1'b1);
      check("t1_mem_addr", bus.mem_addr, 32'h0000_1230);
      check("t1_mem_we", bus.mem_we, 1'b0);
      wait_ack(0, cyc);
      check("t1_latency", cyc + 1, 4);
      check("t1_i_rdata", bus.i_rdata, {32{4'hA}});
      check("t1_d_ack", bus.d_ack, 1'b0);
      bus.i_req = 0;
      @(negedge clk);
      check("t1_ack_pulse", bus.i_ack, 1'b0);

      // Data writeback, memory answers in the 1st cycle
      cfg_lat = 1; cfg_data = {32{4'h5}};
      idle(1);
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100;
      bus.d_wdata = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
      @(negedge clk);
      check("t2_mem_we", bus.mem_we, 1'b1);
      check("t2_mem_addr", bus.mem_addr, 32'h100);
      check("t2_mem_wdata", bus.mem_wdata, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
      wait_ack(1, cyc);
      check("t2_latency", cyc + 1, 2);
      check("t2_d_rdata", bus.d_rdata, 128'h0);
      check("t2_err", bus.err, 1'b0);
      bus.d_req = 0; bus.d_we = 0;

      // Simultaneous requests from reset, re-requesting after each ack
      cfg_lat = 2; cfg_data_en = 0;
      do_reset();
      bus.i_req = 1; bus.i_addr = 32'h1000;
      bus.d_req = 1; bus.d_addr = 32'h2000; bus.d_we = 0;
      ng = 0; guard = 0; prev_req = 0; i_rearm = 0; d_rearm = 0;
      for (int k = 0; k < 4; k++) order[k] = '0;
      exp_order[0] = 32'h2000; exp_order[1] = 32'h1000;
      exp_order[2] = 32'h2000; exp_order[3] = 32'h1000;
      while (ng < 4 && guard < 80) begin
         @(negedge clk);
         guard++;
         if (bus.mem_req && !prev_req) begin order[ng] = bus.mem_addr; ng++; end
         prev_req = bus.mem_req;
         if (i_rearm) begin bus.i_req = 1; i_rearm = 0; end
         else if (bus.i_ack) begin bus.i_req = 0; i_rearm = 1; end
         if (d_rearm) begin bus.d_req = 1; d_rearm = 0; end
         else if (bus.d_ack) begin bus.d_req = 0; d_rearm = 1; end
      end
      check("t3_grants", ng, 4);
      for (int k = 0; k < 4; k++) check($sformatf("t3_order%0d", k), order[k], exp_order[k]);
      bus.i_req = 0; bus.d_req = 0;
      idle(8);

      // Watchdog: memory never answers
      cfg_lat = 0;
      idle(1);
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
      cnt = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bus.mem_req) cnt++;
         else break;
      end
      check("t4_req_cycles", cnt, TMO);
      check("t4_d_ack", bus.d_ack, 1'b1);
      check("t4_err", bus.err, 1'b1);
      check("t4_d_rdata", bus.d_rdata, 128'h0);
      check("t4_i_ack", bus.i_ack, 1'b0);
      bus.d_req = 0;
      @(negedge clk);
      check("t4_ack_pulse", bus.d_ack, 1'b0);
      check("t4_err_pulse", bus.err, 1'b0);

      // Asynchronous reset in the middle of a transfer
      idle(1);
      bus.i_req = 1; bus.i_addr = 32'h500;
      idle(3);
      check("t5_in_mem", bus.mem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_mem_req", bus.mem_req, 1'b0);
      check("t5_mem_addr", bus.mem_addr, 32'h0);
      check("t5_i_ack", bus.i_ack, 1'b0);
      check("t5_d_ack", bus.d_ack, 1'b0);
      check("t5_err", bus.err, 1'b0);
      bus.i_req = 0;
      idle(2);
      rst_n = 1'b1;
      cfg_lat = 2; cfg_data_en = 1; cfg_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
      idle(1);
      bus.i_req = 1; bus.i_addr = 32'h600;
      wait_ack(0, cyc);
      check("t5_i_ack_after", bus.i_ack, 1'b1);
      check("t5_i_rdata", bus.i_rdata, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D);
      check("t5_err_after", bus.err, 1'b0);
      bus.i_req = 0;

      // mem_ready while idle is ignored
      idle(2);
      #1 poke = 1;
      @(negedge clk);
      #1 poke = 0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         check("t6_mem_req", bus.mem_req, 1'b0);
         check("t6_i_ack", bus.i_ack, 1'b0);
         check("t6_d_ack", bus.d_ack, 1'b0);
      end

      // Randomized traffic against the model
      cfg_lat = -1; cfg_data_en = 0; spur_en = 1;
      n_ack = 0; n_err = 0;
      repeat (3000) begin
         @(negedge clk);
         step_rand();
      end
      bus.i_req = 0; bus.d_req = 0;
      idle(20);
      total++;
      if (n_ack < 100) begin bad++; $display("FAIL rand_acks: got %0d required >=100", n_ack); end
      total++;
      if (n_err < 1) begin bad++; $display("FAIL rand_timeouts: got %0d required >=1", n_err); end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sits directly below instr_mem_ctrl and data_mem_ctrl and arbitrates their cache-line refill and writeback requests onto the single main-memory port.
- Round-robin between the instruction and data sides, one transaction outstanding at a time.
- Each transaction is a full line.
- A watchdog terminates transactions the memory never completes.
- The caches' stall outputs depend on this block's ack.

Parameters:
ADDR_W, 32, byte address width.
LINE_W, 128, cache line width in bits (16-byte line, offset bits = 4).
TIMEOUT, 64, maximum cycles to wait for mem_ready; 0 disables the watchdog.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
i_req  in  1  instruction-side line read request, level.
i_addr  in  ADDR_W  instruction line address.
i_ack  out  1  one-cycle completion pulse to the instruction side.
i_rdata  out  LINE_W  returned line, valid while i_ack=1.
d_req  in  1  data-side request, level.
d_we  in  1  1 = line writeback, 0 = line read.
d_addr  in  ADDR_W  data line address.
d_wdata  in  LINE_W  writeback line.
d_ack  out  1  one-cycle completion pulse to the data side.
d_rdata  out  LINE_W  returned line, valid while d_ack=1.
err  out  1  pulses with i_ack/d_ack when the transaction timed out.
mem_req  out  1  memory request, held until mem_ready.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  line-aligned memory address.
mem_wdata  out  LINE_W  memory write data.
mem_ready  in  1  one-cycle memory completion pulse.
mem_rdata  in  LINE_W  memory read data, valid with mem_ready.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, all outputs 0, timer=0, last_grant=I (data wins the first conflict).
  - A transfer in flight is abandoned; the memory must tolerate mem_req dropping.
- FSM states are IDLE, MEM, RESP. All outputs are registered.
- IDLE:
  - Sample i_req/d_req at the clock edge.
  - Only one request: grant it. Both requests: grant the side opposite last_grant.
  - On grant, latch owner, addr with [3:0] forced to 0, we (d_we for data, 0 for instruction) and wdata (d_wdata for data, don't-care/0 for instruction).
  - Go to MEM with mem_req=1 from the next cycle. Set last_grant to the winner.
- MEM:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable.
  - On mem_ready=1: capture mem_rdata (reads) and go to RESP. mem_req drops the cycle after mem_ready.
  - The timer increments every MEM cycle. If TIMEOUT≠0 and timer reaches TIMEOUT-1 without mem_ready: go to RESP with err flagged, rdata=0, mem_req=0.
- RESP:
  - The owner's ack=1 for exactly one cycle, with rdata and err. Then return to IDLE, clearing the timer.
  - Requests are not sampled in RESP.
  - The requester must deassert req in the cycle it sees ack; a req still high in the following IDLE cycle is treated as a new request.
- Writes: the ack carries rdata=0.
- Latency: req high at edge k → mem_req high in cycle k+1. mem_ready at edge m → ack high in cycle m+1. Minimum req→ack is 2 cycles.
- Address changes while req is held are ignored after grant.
- The non-owner's ack is never asserted. i_ack and d_ack are never high together.
- mem_ready outside MEM is ignored.

Decomposition:
- The state encodings (IDLE/MEM/RESP), LINE_OFFSET_W=4 and the owner encoding (OWN_I=0, OWN_D=1) go in the shared parameters.v.
- No sub-module. Grant, FSM and watchdog are small enough to implement inline.

Test Plan:
- i_req=1, i_addr=0x0000_1234; memory returns 0xAAAA...A after 3 cycles → mem_addr=0x0000_1230, mem_we=0, i_ack after 3+1 cycles with i_rdata=0xAAAA...A, d_ack=0.
- d_req=1, d_we=1, d_addr=0x100, d_wdata=0x1122...FF, ready after 1 cycle → mem_we=1, mem_wdata matches, d_ack 2 cycles after req, d_rdata=0.
- i_req and d_req asserted together from reset, each re-requesting after its ack → grant order D, I, D, I, with no overlap of mem_req windows.
- TIMEOUT=8, mem_ready never asserted → mem_req high 8 cycles, then d_ack=1 and err=1 for one cycle, then IDLE.
- reset pulled low in mid-MEM → all outputs 0 immediately. After release, a new i_req is served normally and err=0.
- mem_ready pulsed while in IDLE, with no requests → no ack, state unchanged.
